// File: rtl/speed_seg7_display.sv
// speed_seg7_display
//   Converts a binary speed word to BCD with a sequential shift-add-3
//   (double-dabble) engine. Drives a 3-digit multiplexed common-anode
//   7-segment display with leading-zero blanking and an over-range dash.
//   The whole block runs on the divided display clock.
//
// Parameters
//   SPEED_W  : width of speed_in (10..14)
//   SCAN_DIV : clk cycles each digit stays lit (>= 2)
//
// Ports
//   clk         : display clock
//   rst         : synchronous, active-high reset (all flops)
//   peak_clr    : clears peak and display to 0 (only with peak hold)
//   speed_in    : binary speed, sampled on an accepted load
//   speed_valid : single-cycle load strobe, dropped while busy
//   busy        : high while a conversion is in progress
//   seg_n       : active-low segments {g,f,e,d,c,b,a}
//   dig_n       : active-low one-hot digit enable (0=units,1=tens,2=hundreds)
//
// Optional feature macro: SPEED_DISP_PEAK_HOLD_EN (peak hold + peak_clr port)
module speed_seg7_display #(
  parameter int SPEED_W  = 10,
  parameter int SCAN_DIV = 1024
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SPEED_DISP_PEAK_HOLD_EN
  input  logic               peak_clr,
`endif
  input  logic [SPEED_W-1:0] speed_in,
  input  logic               speed_valid,
  output logic               busy,
  output logic [6:0]         seg_n,
  output logic [2:0]         dig_n
);

  localparam int BIT_W = $clog2(SPEED_W);
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t             state_q, state_d;
  logic [SPEED_W-1:0] bin_q, bin_d;
  logic [SPEED_W-1:0] cap_q, cap_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]         hund_q, hund_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         unit_q, unit_d;
  logic               ovr_q, ovr_d;
`ifdef SPEED_DISP_PEAK_HOLD_EN
  logic [SPEED_W-1:0] peak_q, peak_d;
`endif
  logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]         scan_idx_q, scan_idx_d;
  logic [6:0]         seg_n_q, seg_n_d;
  logic [2:0]         dig_n_q, dig_n_d;

  logic               load_over;
  logic               load_take;

  // One double-dabble step: add 3 to each nibble >= 5, then shift in bit_in.
  function automatic logic [15:0] dabble_step(input logic [15:0] bcd,
                                              input logic        bit_in);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3
                                               : bcd[i*4 +: 4];
    end
    return (adj << 1) | {15'd0, bit_in};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // FSM state register, datapath and scan registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      cap_q      <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      hund_q     <= '0;
      tens_q     <= '0;
      unit_q     <= '0;
      ovr_q      <= 1'b0;
`ifdef SPEED_DISP_PEAK_HOLD_EN
      peak_q     <= '0;
`endif
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_n_q    <= SEG_BLANK;
      dig_n_q    <= 3'b111;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      cap_q      <= cap_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      unit_q     <= unit_d;
      ovr_q      <= ovr_d;
`ifdef SPEED_DISP_PEAK_HOLD_EN
      peak_q     <= peak_d;
`endif
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_n_q    <= seg_n_d;
      dig_n_q    <= dig_n_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (speed_valid) state_d = CONV;
      CONV:    if (bit_cnt_q == BIT_W'(SPEED_W - 1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Conversion datapath
  always_comb begin
    bin_d     = bin_q;
    cap_d     = cap_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    if (state_q == IDLE && speed_valid) begin
      bin_d     = speed_in;
      cap_d     = speed_in;
      bcd_d     = '0;
      bit_cnt_d = '0;
    end else if (state_q == CONV) begin
      bcd_d     = dabble_step(bcd_q, bin_q[SPEED_W-1]);
      bin_d     = {bin_q[SPEED_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end
  end

  // Held digits. The binary compare also catches values >= 10000, whose
  // ten-thousands digit falls off the 4-nibble accumulator.
  always_comb begin
    load_over = (bcd_q[15:12] != 4'd0) || (bcd_q[11:8] > 4'd9) ||
                (cap_q > SPEED_W'(999));
`ifdef SPEED_DISP_PEAK_HOLD_EN
    load_take = (state_q == LOAD) && (cap_q > peak_q);
    peak_d    = peak_q;
`else
    load_take = (state_q == LOAD);
`endif
    hund_d = hund_q;
    tens_d = tens_q;
    unit_d = unit_q;
    ovr_d  = ovr_q;
`ifdef SPEED_DISP_PEAK_HOLD_EN
    if (peak_clr) begin
      hund_d = '0;
      tens_d = '0;
      unit_d = '0;
      ovr_d  = 1'b0;
      peak_d = '0;
    end else
`endif
    if (load_take) begin
`ifdef SPEED_DISP_PEAK_HOLD_EN
      peak_d = cap_q;
`endif
      if (load_over) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d  = 1'b0;
        hund_d = bcd_q[11:8];
        tens_d = bcd_q[7:4];
        unit_d = bcd_q[3:0];
      end
    end
  end

  // Digit scan; seg_n and dig_n are registered together so they switch on
  // the same edge.
  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == 2'd2) ? 2'd0 : scan_idx_q + 2'd1;
    end
    case (scan_idx_q)
      2'd1: begin
        dig_n_d = 3'b101;
        seg_n_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : seg_code(tens_q);
      end
      2'd2: begin
        dig_n_d = 3'b011;
        seg_n_d = (hund_q == 4'd0) ? SEG_BLANK : seg_code(hund_q);
      end
      default: begin
        dig_n_d = 3'b110;
        seg_n_d = seg_code(unit_q);
      end
    endcase
    if (ovr_q) seg_n_d = SEG_DASH;
  end

  assign seg_n = seg_n_q;
  assign dig_n = dig_n_q;

endmodule

// File: tb/tb_speed_seg7_display.sv
module tb_speed_seg7_display;

  localparam int SPEED_W  = 10;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [5:0] DIGS = {3'b011, 3'b101};

  logic               clk = 1'b0;
  logic               rst;
  logic [SPEED_W-1:0] speed_in;
  logic               speed_valid;
  logic               busy;
  logic [6:0]         seg_n;
  logic [2:0]         dig_n;
`ifdef SPEED_DISP_PEAK_HOLD_EN
  logic               peak_clr;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  speed_seg7_display #(.SPEED_W(SPEED_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SPEED_DISP_PEAK_HOLD_EN
    .peak_clr   (peak_clr),
`endif
    .speed_in   (speed_in),
    .speed_valid(speed_valid),
    .busy       (busy),
    .seg_n      (seg_n),
    .dig_n      (dig_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [SPEED_W-1:0] v);
    speed_in    = v;
    speed_valid = 1'b1;
    step();
    speed_valid = 1'b0;
  endtask

  // Issues a load and counts the cycles busy is seen high (bounded).
  task automatic load_and_wait(input logic [SPEED_W-1:0] v, output int bcycles);
`ifdef SPEED_DISP_PEAK_HOLD_EN
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
`endif
    start_load(v);
    bcycles = 0;
    while (busy && bcycles < 40) begin
      bcycles++;
      step();
    end
  endtask

  // Records the first cycle of each digit slot: segs = {hund,tens,units},
  // digs = {dig_n in hundreds slot, dig_n in tens slot}. X on timeout.
  task automatic capture_digits(output logic [20:0] segs, output logic [5:0] digs);
    int n = 0;
    segs = 'x;
    digs = 'x;
    while (dig_n !== 3'b011 && n < 40) begin n++; step(); end
    while (dig_n !== 3'b110 && n < 40) begin n++; step(); end
    if (n < 40) begin
      segs[6:0] = seg_n;
      repeat (SCAN_DIV) step();
      segs[13:7] = seg_n;
      digs[2:0]  = dig_n;
      repeat (SCAN_DIV) step();
      segs[20:14] = seg_n;
      digs[5:3]   = dig_n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    speed_valid = 1'b0;
    speed_in = '0;
`ifdef SPEED_DISP_PEAK_HOLD_EN
    peak_clr = 1'b0;
`endif
    repeat (3) step();
    vec_cnt++;
    if ({busy, seg_n, dig_n} !== {1'b0, SB, 3'b111}) begin
      err_cnt++;
      $display("FAIL reset_hold: got busy/seg/dig=%b/%b/%b want 0/%b/111", busy, seg_n, dig_n, SB);
    end
    rst = 1'b0;
    step();
    vec_cnt++;
    if ({seg_n, dig_n} !== {S0, 3'b110}) begin
      err_cnt++;
      $display("FAIL reset_units: got seg/dig=%b/%b want %b/110", seg_n, dig_n, S0);
    end
    repeat (SCAN_DIV) step();
    vec_cnt++;
    if ({seg_n, dig_n} !== {SB, 3'b101}) begin
      err_cnt++;
      $display("FAIL reset_tens: got seg/dig=%b/%b want %b/101", seg_n, dig_n, SB);
    end
    repeat (SCAN_DIV) step();
    vec_cnt++;
    if ({seg_n, dig_n} !== {SB, 3'b011}) begin
      err_cnt++;
      $display("FAIL reset_hund: got seg/dig=%b/%b want %b/011", seg_n, dig_n, SB);
    end
  endtask

  task automatic test_convert_157();
    int bc;
    logic [20:0] segs;
    logic [5:0]  digs;
    load_and_wait(10'd157, bc);
    vec_cnt++;
    if (bc != SPEED_W + 1) begin
      err_cnt++;
      $display("FAIL busy_len_157: got %0d cycles want %0d", bc, SPEED_W + 1);
    end
    capture_digits(segs, digs);
    vec_cnt++;
    if (segs !== {S1, S5, S7}) begin
      err_cnt++;
      $display("FAIL disp_157: got %b want %b", segs, {S1, S5, S7});
    end
    vec_cnt++;
    if (digs !== DIGS) begin
      err_cnt++;
      $display("FAIL dig_seq_157: got %b want %b", digs, DIGS);
    end
  endtask

  task automatic test_blanking();
    int bc;
    logic [20:0] segs;
    logic [5:0]  digs;
    load_and_wait(10'd7, bc);
    capture_digits(segs, digs);
    vec_cnt++;
    if (segs !== {SB, SB, S7}) begin
      err_cnt++;
      $display("FAIL disp_7: got %b want %b", segs, {SB, SB, S7});
    end
    load_and_wait(10'd40, bc);
    capture_digits(segs, digs);
    vec_cnt++;
    if (segs !== {SB, S4, S0}) begin
      err_cnt++;
      $display("FAIL disp_40: got %b want %b", segs, {SB, S4, S0});
    end
  endtask

  task automatic test_overrange();
    int bc;
    logic [20:0] segs;
    logic [5:0]  digs;
    load_and_wait(10'd1000, bc);
    vec_cnt++;
    if (bc != SPEED_W + 1) begin
      err_cnt++;
      $display("FAIL busy_len_1000: got %0d cycles want %0d", bc, SPEED_W + 1);
    end
    capture_digits(segs, digs);
    vec_cnt++;
    if (segs !== {SD, SD, SD}) begin
      err_cnt++;
      $display("FAIL disp_1000: got %b want %b", segs, {SD, SD, SD});
    end
    load_and_wait(10'd999, bc);
    capture_digits(segs, digs);
    vec_cnt++;
    if (segs !== {S9, S9, S9}) begin
      err_cnt++;
      $display("FAIL disp_999: got %b want %b", segs, {S9, S9, S9});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [20:0] segs;
    logic [5:0]  digs;
`ifdef SPEED_DISP_PEAK_HOLD_EN
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
`endif
    start_load(10'd123);
    step();
    step();
    start_load(10'd222);
    n = 0;
    while (busy && n < 40) begin n++; step(); end
    vec_cnt++;
    if (n != SPEED_W - 2) begin
      err_cnt++;
      $display("FAIL busy_len_drop: got %0d remaining cycles want %0d", n, SPEED_W - 2);
    end
    repeat (3) step();
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL drop_no_restart: got busy=%b want 0", busy);
    end
    capture_digits(segs, digs);
    vec_cnt++;
    if (segs !== {S1, S2, S3}) begin
      err_cnt++;
      $display("FAIL disp_123: got %b want %b", segs, {S1, S2, S3});
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [20:0] segs;
    logic [5:0]  digs;
    start_load(10'd456);
    repeat (4) step();
    rst = 1'b1;
    step();
    vec_cnt++;
    if ({busy, seg_n, dig_n} !== {1'b0, SB, 3'b111}) begin
      err_cnt++;
      $display("FAIL rst_mid_conv: got busy/seg/dig=%b/%b/%b want 0/%b/111", busy, seg_n, dig_n, SB);
    end
    rst = 1'b0;
    step();
    capture_digits(segs, digs);
    vec_cnt++;
    if (segs !== {SB, SB, S0}) begin
      err_cnt++;
      $display("FAIL disp_after_rst: got %b want %b", segs, {SB, SB, S0});
    end
  endtask

`ifdef SPEED_DISP_PEAK_HOLD_EN
  task automatic test_peak();
    logic [20:0] segs;
    logic [5:0]  digs;
    logic [SPEED_W-1:0] vals [3] = '{10'd80, 10'd60, 10'd95};
    logic [20:0]        exps [3] = '{{SB, S8, S0}, {SB, S8, S0}, {SB, S9, S5}};
    int n;
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_load(vals[i]);
      n = 0;
      while (busy && n < 40) begin n++; step(); end
      capture_digits(segs, digs);
      vec_cnt++;
      if (segs !== exps[i]) begin
        err_cnt++;
        $display("FAIL peak_%0d: got %b want %b", vals[i], segs, exps[i]);
      end
    end
    start_load(10'd120);
    repeat (SPEED_W) step();
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL peak_clr_busy: got busy=%b want 0", busy);
    end
    capture_digits(segs, digs);
    vec_cnt++;
    if (segs !== {SB, SB, S0}) begin
      err_cnt++;
      $display("FAIL peak_clr_disp: got %b want %b", segs, {SB, SB, S0});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_convert_157();
    test_blanking();
    test_overrange();
    test_back_to_back();
    test_reset_mid_conv();
`ifdef SPEED_DISP_PEAK_HOLD_EN
    test_peak();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
